// File: rtl/matmul_pkg.sv
// Shared types and helpers for the systolic MatMul operand loaders.
package matmul_pkg;

  typedef enum logic [1:0] {LOAD, FULL, SHIFT, DONE} matb_state_t;

  function automatic int idx_w(input int depth);
    return $clog2(depth * depth);
  endfunction

endpackage

// File: rtl/matrix_b_addr_gen.sv
// Element counter for the B-operand load; maps the stream index to buffer row/col.
// MATB_COLMAJOR_EN selects a column-major stream (B arrives already transposed).
module matrix_b_addr_gen
  import matmul_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        inc,
  output logic [idx_w(DEPTH)-1:0]     idx,
  output logic                        last,
  output logic [$clog2(DEPTH)-1:0]    row,
  output logic [$clog2(DEPTH)-1:0]    col
);

  localparam int RW = $clog2(DEPTH);
  localparam int IW = idx_w(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == IW'(DEPTH * DEPTH - 1));

  // DEPTH is a power of two, so k/DEPTH and k%DEPTH are just the high and low halves of idx.
`ifdef MATB_COLMAJOR_EN
  assign row = idx[RW-1:0];
  assign col = idx[IW-1:RW];
`else
  assign row = idx[IW-1:RW];
  assign col = idx[RW-1:0];
`endif

endmodule

// File: rtl/matrix_b_load_ctrl.sv
// Sequencer for the transposed-load B-operand shift buffer: LOAD -> FULL -> SHIFT -> DONE.
// MATB_COLMAJOR_EN (see matrix_b_addr_gen) switches the stream to column-major order.
module matrix_b_load_ctrl
  import matmul_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [BITS-1:0]    in_data,
  input  logic                      start,
  output logic                      loaded,
  output logic                      busy,
  output logic                      row_valid,
  output logic [$clog2(DEPTH)-1:0]  row_idx,
  output logic                      done,
  output logic                      buf_WrEn,
  output logic                      buf_en,
  output logic [$clog2(DEPTH)-1:0]  buf_row,
  output logic [$clog2(DEPTH)-1:0]  buf_col,
  output logic signed [BITS-1:0]    buf_d
);

  localparam int RW = $clog2(DEPTH);
  localparam int IW = idx_w(DEPTH);

  matb_state_t     state, state_d;
  logic [RW-1:0]   scnt;
  logic [IW-1:0]   idx;
  logic            idx_last;
  logic [RW-1:0]   map_row, map_col;
  logic            accept;

  assign accept = in_valid && in_ready;

  matrix_b_addr_gen #(.DEPTH(DEPTH)) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == DONE),
    .inc   (accept && !idx_last),
    .idx   (idx),
    .last  (idx_last),
    .row   (map_row),
    .col   (map_col)
  );

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    loaded    = 1'b0;
    busy      = 1'b0;
    row_valid = 1'b0;
    buf_en    = 1'b0;
    done      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (accept && idx_last) state_d = FULL;
      end
      FULL: begin
        loaded = 1'b1;
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        row_valid = 1'b1;
        buf_en    = 1'b1;
        if (scnt == RW'(DEPTH - 1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign row_idx = scnt;

  // The write port lags the accept by one cycle; it only fires from LOAD, so it can never meet buf_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      scnt     <= '0;
      buf_WrEn <= 1'b0;
      buf_row  <= '0;
      buf_col  <= '0;
      buf_d    <= '0;
    end else begin
      state    <= state_d;
      buf_WrEn <= accept;
      if (state == SHIFT && scnt != RW'(DEPTH - 1)) begin
        scnt <= scnt + 1'b1;
      end else begin
        scnt <= '0;
      end
      if (accept) begin
        buf_row <= map_row;
        buf_col <= map_col;
        buf_d   <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_b_load_ctrl.sv
// Directed bench for matrix_b_load_ctrl with a behavioural DEPTH x DEPTH shift buffer.
// Expectations follow MATB_COLMAJOR_EN when the bench is built with that macro.
module tb_matrix_b_load_ctrl;

  localparam int DEPTH = 4;
  localparam int BITS  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_data = '0;
  logic              start = 1'b0;
  logic              loaded, busy, row_valid, done;
  logic [1:0]        row_idx;
  logic              buf_WrEn, buf_en;
  logic [1:0]        buf_row, buf_col;
  logic signed [7:0] buf_d;

  logic [7:0] mem [DEPTH][DEPTH];
  int vectors = 0;
  int miscompares = 0;
  int enCount = 0;
  logic prevDone = 1'b0;

  always #5 clk = ~clk;

  matrix_b_load_ctrl #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .start     (start),
    .loaded    (loaded),
    .busy      (busy),
    .row_valid (row_valid),
    .row_idx   (row_idx),
    .done      (done),
    .buf_WrEn  (buf_WrEn),
    .buf_en    (buf_en),
    .buf_row   (buf_row),
    .buf_col   (buf_col),
    .buf_d     (buf_d)
  );

  // Reference shift buffer: write has priority, shift moves row r+1 into row r and zero-fills the top.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++)
        for (int c = 0; c < DEPTH; c++) mem[r][c] <= '0;
    end else if (buf_WrEn) begin
      mem[buf_row][buf_col] <= buf_d;
    end else if (buf_en) begin
      for (int r = 0; r < DEPTH - 1; r++)
        for (int c = 0; c < DEPTH; c++) mem[r][c] <= mem[r+1][c];
      for (int c = 0; c < DEPTH; c++) mem[DEPTH-1][c] <= '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    start    = s;
    @(posedge clk);
    #1;
  endtask

  function automatic int elemAt(input int r, input int c);
`ifdef MATB_COLMAJOR_EN
    return DEPTH * c + r;
`else
    return DEPTH * r + c;
`endif
  endfunction

  function automatic int rowOf(input int k);
`ifdef MATB_COLMAJOR_EN
    return k % DEPTH;
`else
    return k / DEPTH;
`endif
  endfunction

  function automatic int colOf(input int k);
`ifdef MATB_COLMAJOR_EN
    return k / DEPTH;
`else
    return k % DEPTH;
`endif
  endfunction

  task automatic checkWrite(input string tag, input int k);
    checkOutput({tag, "_wren"}, buf_WrEn, 1);
    checkOutput({tag, "_row"}, buf_row, rowOf(k));
    checkOutput({tag, "_col"}, buf_col, colOf(k));
    checkOutput({tag, "_d"}, buf_d, k);
  endtask

  task automatic checkImage(input string tag);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < DEPTH; c++) checkOutput(tag, mem[r][c], elemAt(r, c));
  endtask

  task automatic checkZero(input string tag);
    for (int r = 0; r < DEPTH; r++)
      for (int c = 0; c < DEPTH; c++) checkOutput(tag, mem[r][c], 0);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_loaded"}, loaded, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_buf_en"}, buf_en, 0);
    checkOutput({tag, "_row_valid"}, row_valid, 0);
  endtask

  task automatic loadAll(input string tag);
    for (int k = 0; k < DEPTH * DEPTH; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0);
      checkWrite(tag, k);
    end
    checkOutput({tag, "_loaded"}, loaded, 1);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput({tag, "_wren_off"}, buf_WrEn, 0);
    checkOutput({tag, "_loaded_hold"}, loaded, 1);
    checkImage({tag, "_image"});
  endtask

  task automatic shiftOut(input string tag, input logic holdStart);
    applyStimulus(1'b0, 8'd0, 1'b1);
    for (int s = 0; s < DEPTH; s++) begin
      checkOutput({tag, "_busy"}, busy, 1);
      checkOutput({tag, "_buf_en"}, buf_en, 1);
      checkOutput({tag, "_row_valid"}, row_valid, 1);
      checkOutput({tag, "_row_idx"}, row_idx, s);
      checkOutput({tag, "_q0"}, mem[0][0], elemAt(s, 0));
      applyStimulus(1'b0, 8'd0, holdStart);
    end
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busy_off"}, busy, 0);
    checkOutput({tag, "_en_off"}, buf_en, 0);
    checkZero({tag, "_zero"});
    applyStimulus(1'b0, 8'd0, holdStart);
    checkIdle({tag, "_rearm"});
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkIdle({tag, "_stay_load"});
  endtask

  // Invariant watch, sampled on the falling edge.
  always @(negedge clk) begin
    if (buf_WrEn === 1'b1 || buf_en === 1'b1)
      checkOutput("wren_en_exclusive", 32'(buf_WrEn && buf_en), 0);
    if (done === 1'b1) begin
      checkOutput("done_single_pulse", prevDone, 0);
      checkOutput("en_cycles_per_start", enCount, DEPTH);
    end
    prevDone = (done === 1'b1);
    if (!rst_n || done === 1'b1) enCount = 0;
    else if (buf_en === 1'b1) enCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accepted;
    int step;
    logic v;
    logic [4:0] gapPattern;

    $display("[TB] reset");
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkIdle("reset");
    checkOutput("reset_wren", buf_WrEn, 0);
    rst_n = 1'b1;

    $display("[TB] full load and shift");
    loadAll("load1");
    shiftOut("shift1", 1'b0);

    $display("[TB] gapped stream, start ignored outside FULL");
    gapPattern = 5'b01101;
    accepted = 0;
    step = 0;
    while (accepted < DEPTH * DEPTH && step < 100) begin
      v = gapPattern[step % 5];
      applyStimulus(v, 8'(accepted), !v);
      checkOutput("gap_wren", buf_WrEn, 32'(v));
      checkOutput("gap_busy", busy, 0);
      if (v) begin
        checkWrite("gap", accepted);
        accepted++;
      end
      checkOutput("gap_loaded", loaded, 32'(accepted == DEPTH * DEPTH));
      step++;
    end
    checkOutput("gap_accepts", accepted, DEPTH * DEPTH);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkImage("gap_image");
    shiftOut("gap_shift", 1'b1);

    $display("[TB] reset after 7 accepts");
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 8'(k), 1'b0);
    checkWrite("mid7", 6);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkIdle("rst_load");
    checkOutput("rst_load_wren", buf_WrEn, 0);
    checkZero("rst_load_zero");
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'd0, 1'b0);
    checkWrite("rst_load_idx0", 0);
    applyStimulus(1'b0, 8'd0, 1'b0);

    $display("[TB] reset together with start in FULL");
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;
    loadAll("load_rw");
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkIdle("rst_wins");
    checkZero("rst_wins_zero");
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0);

    $display("[TB] reset at SHIFT scnt=2");
    loadAll("load_rs");
    applyStimulus(1'b0, 8'd0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("rs_row_idx", row_idx, 2);
    checkOutput("rs_busy", busy, 1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkIdle("rst_shift");
    checkZero("rst_shift_zero");
    rst_n = 1'b1;

    $display("[TB] reload after reset");
    loadAll("load2");
    shiftOut("shift2", 1'b0);

    applyStimulus(1'b0, 8'd0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
